multiplier_module: RTL and testbench

//  Kahn-process-network multiplier node. Each cycle of operation it pops one token from each of two input

---
 rtl/kpn_pkg.sv | 15 +
 rtl/multiplier_module_if.sv | 32 +++
 rtl/multiplier_module_shift_add_datapath.sv | 65 ++++++
 rtl/multiplier_module.sv | 84 ++++++++
 tb/tb_multiplier_module.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN node slice: token width and the
// multiplier node state type.
package kpn_pkg;

  localparam int unsigned KPN_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    MUL,
    WRITE
  } mult_state_t;

endpackage

// File: rtl/multiplier_module_if.sv
// Channel bundle for the multiplier node: two upstream FIFO taps popped by
// rd, one downstream FIFO pushed by wr.
// master: the multiplier node. slave: the FIFO side.
interface multiplier_module_if
  import kpn_pkg::*;
#(
  parameter int unsigned WIDTH = KPN_DATA_W
);

  logic [WIDTH-1:0]   entry_1;
  logic [WIDTH-1:0]   entry_2;
  logic               rd;
  logic               wr;
  logic [2*WIDTH-1:0] output_1;

  modport master (
    input  entry_1,
    input  entry_2,
    output rd,
    output wr,
    output output_1
  );

  modport slave (
    output entry_1,
    output entry_2,
    input  rd,
    input  wr,
    input  output_1
  );

endinterface

// File: rtl/multiplier_module_shift_add_datapath.sv
// Shift-add datapath: operand, accumulator and bit-count registers plus the
// adder. One multiplier bit is consumed per step.
// Optional feature macro: MULTIPLIER_SIGNED_EN (two's complement operands).
module shift_add_datapath
  import kpn_pkg::*;
#(
  parameter int unsigned WIDTH = KPN_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               last
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] partial;

  assign last = (count == CNT_W'(WIDTH - 1));

  // Next accumulator value for the current multiplier bit.
  always_comb begin
    partial  = mplier[0] ? (mcand << count) : '0;
    acc_next = acc + partial;
`ifdef MULTIPLIER_SIGNED_EN
    // The multiplier MSB carries weight -2^(WIDTH-1), so the final step
    // subtracts; this keeps the signed result within WIDTH steps.
    if (last) begin
      acc_next = acc - partial;
    end
`endif
  end

  // Operand capture on load, one shift-add step per cycle on step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
`ifdef MULTIPLIER_SIGNED_EN
      mcand  <= {{WIDTH{op_a[WIDTH-1]}}, op_a};
`else
      mcand  <= {{WIDTH{1'b0}}, op_a};
`endif
      mplier <= op_b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multiplier_module.sv
// Kahn-process-network multiplier node: pops one token from each input
// channel, multiplies them iteratively (one bit per clock) and pushes the
// 2*WIDTH product. Token period is WIDTH+3 cycles, data independent.
// Optional feature macro: MULTIPLIER_SIGNED_EN (signed operands/product).
module multiplier_module
  import kpn_pkg::*;
#(
  parameter int unsigned WIDTH = KPN_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  multiplier_module_if.master bus
);

  mult_state_t        state;
  logic               rd_q;
  logic               wr_q;
  logic [2*WIDTH-1:0] out_q;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;
  logic               load;
  logic               step;

  assign load = (state == LOAD);
  assign step = (state == MUL);

  shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .op_a     (bus.entry_1),
    .op_b     (bus.entry_2),
    .acc_next (acc_next),
    .last     (last)
  );

  // Sequencer with registered strobes; the product is latched on the final
  // MUL edge so it is already valid during the wr cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      out_q <= '0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      case (state)
        IDLE: begin
          state <= READ;
          rd_q  <= 1'b1;
        end
        READ: begin
          state <= LOAD;
        end
        LOAD: begin
          state <= MUL;
        end
        MUL: begin
          if (last) begin
            state <= WRITE;
            wr_q  <= 1'b1;
            out_q <= acc_next;
          end
        end
        WRITE: begin
          state <= READ;
          rd_q  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd       = rd_q;
  assign bus.wr       = wr_q;
  assign bus.output_1 = out_q;

endmodule

// File: tb/tb_multiplier_module.sv
// Scoreboard bench for multiplier_module: the FIFO-side driver pushes the
// expected product when it supplies operands; the monitor pops on wr.
module tb_multiplier_module;
  import kpn_pkg::*;

  localparam int unsigned W = KPN_DATA_W;

  logic clk = 1'b0;
  logic rst_n;

  multiplier_module_if #(.WIDTH(W)) bus ();

  multiplier_module #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cycle = 0;
  int unsigned written = 0;
  int unsigned issued = 0;

  logic [2*W-1:0] exp_q[$];
  int unsigned    rd_cyc_q[$];
  logic [W-1:0]   dir_a[$];
  logic [W-1:0]   dir_b[$];
  logic [2*W-1:0] last_out = '0;
  int unsigned    last_rd_cyc = 0;
  bit             have_last_rd = 1'b0;
  bit             load_now = 1'b0;

  always @(posedge clk) cycle++;

  // Reference: plain arithmetic product.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTIPLIER_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (2*W)'(sa * sb);
`else
    longint unsigned ua;
    longint unsigned ub;
    ua = longint'(a);
    ub = longint'(b);
    return (2*W)'(ua * ub);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: reset values, strobe exclusivity, products, latency, period, hold.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (!rst_n) begin
      check("reset_rd", bus.rd, 0);
      check("reset_wr", bus.wr, 0);
      check("reset_out", bus.output_1, 0);
      exp_q.delete();
      rd_cyc_q.delete();
      last_out = '0;
      have_last_rd = 1'b0;
      load_now = 1'b0;
    end else begin
      check("rd_wr_overlap", bus.rd & bus.wr, 0);
      load_now = bus.rd;
      if (bus.rd) begin
        if (have_last_rd) check("rd_period", cycle - last_rd_cyc, W + 3);
        last_rd_cyc = cycle;
        have_last_rd = 1'b1;
        rd_cyc_q.push_back(cycle);
      end
      if (bus.wr) begin
        check("wr_has_expect", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("product", bus.output_1, e);
          last_out = e;
        end
        check("wr_has_rd", rd_cyc_q.size() != 0, 1);
        if (rd_cyc_q.size() != 0) check("latency", cycle - rd_cyc_q.pop_front(), W + 2);
        written++;
      end else begin
        check("hold", bus.output_1, last_out);
      end
    end
  end

  // FIFO-side driver: operands valid the cycle after rd, noise otherwise.
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.entry_1 = '0;
    bus.entry_2 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (load_now && rst_n) begin
        if (dir_a.size() != 0) begin
          a = dir_a.pop_front();
          b = dir_b.pop_front();
        end else begin
          a = W'($urandom);
          b = W'($urandom);
        end
        bus.entry_1 = a;
        bus.entry_2 = b;
        exp_q.push_back(model(a, b));
        issued++;
      end else begin
        bus.entry_1 = W'($urandom);
        bus.entry_2 = W'($urandom);
      end
    end
  end

  task automatic wait_written(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (written < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("written_count", written >= n, 1);
  endtask

  task automatic wait_rd(input int unsigned budget, input string name);
    int unsigned k = 0;
    while (!bus.rd && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.rd, 1);
  endtask

  initial begin
    int unsigned w0;
    dir_a = {16'h0010, 16'h0020, 16'h0030, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000};
    dir_b = {16'h0032, 16'h0020, 16'h0030, 16'hFFFF, 16'h1234, 16'h0002, 16'h8000};
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rd_after_edge1", bus.rd, 1);
    @(posedge clk);
    #1 check("rd_after_edge2", bus.rd, 0);

    // Directed tokens, then random ones.
    wait_written(7, 7 * 25);
    wait_written(37, 30 * 25);

    // Reset in the middle of MUL: token is dropped, node restarts.
    @(negedge clk);
    wait_rd(30, "rd_before_midreset");
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_wr", bus.wr, 0);
    check("midreset_out", bus.output_1, 0);
    w0 = written;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_rd(5, "rd_after_midreset");
    check("no_wr_from_dropped", written, w0);
    wait_written(w0 + 5, 5 * 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
